// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq -- multi-cycle control sequencer for the RV32I core.
//
// Steps every instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// It handshakes with instruction and data memory, and turns the decoder's
// flags into write enables and mux selects for the PC, IR, register file
// and CSR file. It also counts retired instructions, watches for memory
// accesses that never complete, and parks the core in HALT on request.
//
// Ports
//   clock, reset        core clock; synchronous active-low reset
//   imem_req / imem_ack instruction fetch handshake
//   ir_we               load the instruction register (the cycle imem_ack is seen)
//   jal .. csr_write    decoder flags for the instruction held in IR
//   illegal             IR does not hold a supported opcode
//   br_taken            ALU compare result for conditional branches
//   dmem_req / dmem_we  data access request and its direction (1 = store)
//   dmem_ack            data access complete
//   pc_we, pc_sel       PC update and its source (0 pc+4, 1 pc+imm, 2 ALU)
//   rf_we, csr_we       register file / CSR file write enables
//   wb_sel              register write-back source (0 ALU, 1 load, 2 pc+4)
//   halt_req, halted    halt at the next instruction boundary / parked
//   error               sticky fault flag (timeout or illegal opcode)
//   state_o             current state encoding, for debug and checkers
//   instret             retired instruction count, wraps modulo 2^CNT_W
//
// Memory handshake (both ports): a request is held high every cycle the
// sequencer waits in FETCH or MEM. The access completes in the cycle the
// matching ack is high while the request is high; acks seen in any other
// cycle are ignored. The sequencer never drops a request before its ack
// unless the wait counter expires, which moves it to ERROR.
//
// All outputs are forced to 0 while reset is low.
// ---------------------------------------------------------------------------
module core_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic             jal,
  input  logic             jalr,
  input  logic             branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             csr_write,
  input  logic             illegal,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             csr_we,
  output logic [1:0]       wb_sel,
  input  logic             halt_req,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Wait counter only has to reach TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_error;
  logic [CNT_W-1:0] r_instret;

  logic             w_waiting;
  logic             w_expire;

  // A wait cycle is a FETCH or MEM cycle whose ack has not arrived.
  // Because both wait states are only entered from other states, clearing
  // the counter whenever we are not waiting is the same as clearing it on
  // entry, and an ack always restarts the count for the next access.
  assign w_waiting = ((r_state == S_FETCH) && !imem_ack) ||
                     ((r_state == S_MEM)   && !dmem_ack);

  // An ack in the last allowed cycle keeps w_waiting low, so progress wins.
  assign w_expire  = TO_EN && w_waiting && (r_to_cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // Wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (w_waiting) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flag: set on the way into ERROR, cleared only by reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if (w_next == S_ERROR) begin
      r_error <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Retired instruction counter: one retire per WB cycle, wraps naturally.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_instret <= '0;
    end else if (r_state == S_WB) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control outputs. Everything defaults to 0 and is only
  // driven while reset is high, so nothing fires during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    rf_we    = 1'b0;
    csr_we   = 1'b0;
    wb_sel   = 2'd0;
    halted   = 1'b0;

    if (reset) begin
      unique case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            // Instruction is captured in the same cycle it arrives.
            ir_we  = 1'b1;
            w_next = S_DECODE;
          end else if (w_expire) begin
            w_next = S_ERROR;
          end
        end

        S_DECODE: begin
          w_next = illegal ? S_ERROR : S_EXEC;
        end

        S_EXEC: begin
          w_next = (mem_read || mem_write) ? S_MEM : S_WB;
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ack) begin
            w_next = S_WB;
          end else if (w_expire) begin
            w_next = S_ERROR;
          end
        end

        S_WB: begin
          pc_we  = 1'b1;
          // Stores and branches never write rd even if the flag is set.
          rf_we  = reg_write && !mem_write && !branch;
          csr_we = csr_write;
          if (jalr) begin
            pc_sel = 2'd2;
          end else if (jal || (branch && br_taken)) begin
            pc_sel = 2'd1;
          end
          if (jal || jalr) begin
            wb_sel = 2'd2;
          end else if (mem_read) begin
            wb_sel = 2'd1;
          end
          w_next = halt_req ? S_HALT : S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
          if (!halt_req) begin
            w_next = S_FETCH;
          end
        end

        S_ERROR: begin
          w_next = S_ERROR;
        end

        default: begin
          // Unused encoding 7 is treated as a fault.
          w_next = S_ERROR;
        end
      endcase
    end
  end

  assign error   = reset ? r_error   : 1'b0;
  assign state_o = reset ? r_state   : 3'd0;
  assign instret = reset ? r_instret : '0;

endmodule

// File: tb/tb_core_seq.sv
// ---------------------------------------------------------------------------
// tb_core_seq -- self-checking bench for core_seq.
//
// Two instances share all inputs: one with the default 32-bit counter and
// one with a 4-bit counter for the wrap case. Driver tasks describe each
// instruction (kind, wait states, halt) and push the expected output vector
// for every cycle into exp_q; a compare process pops and checks one entry
// per cycle at the falling edge. Inputs change 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_core_seq;

  localparam int TIMEOUT = 16;

  logic clock;
  logic reset;
  logic imem_ack, dmem_ack;
  logic jal, jalr, branch, mem_read, mem_write, reg_write, csr_write, illegal;
  logic br_taken, halt_req;

  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, csr_we, halted, error;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state_o;
  logic [31:0] instret;

  logic        imem_req_4, ir_we_4, dmem_req_4, dmem_we_4, pc_we_4, rf_we_4, csr_we_4;
  logic        halted_4, error_4;
  logic [1:0]  pc_sel_4, wb_sel_4;
  logic [2:0]  state_o_4;
  logic [3:0]  instret_4;

  core_seq #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .jal(jal), .jalr(jalr), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .csr_write(csr_write),
    .illegal(illegal), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .csr_we(csr_we),
    .wb_sel(wb_sel), .halt_req(halt_req), .halted(halted), .error(error),
    .state_o(state_o), .instret(instret)
  );

  core_seq #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req_4), .imem_ack(imem_ack), .ir_we(ir_we_4),
    .jal(jal), .jalr(jalr), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .csr_write(csr_write),
    .illegal(illegal), .br_taken(br_taken),
    .dmem_req(dmem_req_4), .dmem_we(dmem_we_4), .dmem_ack(dmem_ack),
    .pc_we(pc_we_4), .pc_sel(pc_sel_4), .rf_we(rf_we_4), .csr_we(csr_we_4),
    .wb_sel(wb_sel_4), .halt_req(halt_req), .halted(halted_4), .error(error_4),
    .state_o(state_o_4), .instret(instret_4)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // Expected-vector types and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic        csr_we;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        error;
    logic [31:0] instret;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  typedef struct packed {
    logic jal, jalr, branch, mem_read, mem_write, reg_write, csr_write, illegal;
  } flags_t;

  // Field order: jal jalr branch mem_read mem_write reg_write csr_write illegal
  localparam flags_t F_ADD   = 8'b0000_0100;
  localparam flags_t F_LW    = 8'b0001_0100;
  localparam flags_t F_SW    = 8'b0000_1000;
  localparam flags_t F_BEQ   = 8'b0010_0000;
  localparam flags_t F_JAL   = 8'b1000_0100;
  localparam flags_t F_JALR  = 8'b0100_0100;
  localparam flags_t F_CSR   = 8'b0000_0110;
  localparam flags_t F_SW_RW = 8'b0000_1100;
  localparam flags_t F_BR_RW = 8'b0010_0100;
  localparam flags_t F_ILL   = 8'b0000_0001;

  localparam flags_t KINDS [0:8] = '{F_ADD, F_LW, F_SW, F_BEQ, F_JAL, F_JALR,
                                     F_CSR, F_SW_RW, F_BR_RW};

  logic [OBS_W-1:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  int               n_push;
  logic [31:0]      m_instret;   // model's retired count

  // ---------------------------------------------------------------------------
  // Compare process: one expected vector per cycle, checked on both DUTs.
  // ---------------------------------------------------------------------------
  obs_t c_exp, c_exp4, c_act, c_act4;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      c_exp = obs_t'(exp_q.pop_front());

      c_act = '{st: state_o, imem_req: imem_req, ir_we: ir_we, dmem_req: dmem_req,
                dmem_we: dmem_we, pc_we: pc_we, pc_sel: pc_sel, rf_we: rf_we,
                csr_we: csr_we, wb_sel: wb_sel, halted: halted, error: error,
                instret: instret};
      c_act4 = '{st: state_o_4, imem_req: imem_req_4, ir_we: ir_we_4, dmem_req: dmem_req_4,
                 dmem_we: dmem_we_4, pc_we: pc_we_4, pc_sel: pc_sel_4, rf_we: rf_we_4,
                 csr_we: csr_we_4, wb_sel: wb_sel_4, halted: halted_4, error: error_4,
                 instret: {28'd0, instret_4}};
      c_exp4 = c_exp;
      c_exp4.instret = {28'd0, c_exp.instret[3:0]};

      // wb_sel only carries meaning in WB.
      if (c_exp.st != 3'd4) begin
        c_act.wb_sel  = 2'd0;
        c_act4.wb_sel = 2'd0;
      end

      n_checks++;
      if (c_act !== c_exp) begin
        n_errors++;
        $display("FAIL trace32 t=%0t got st=%0d req=%b%b%b%b pc_we=%b pc_sel=%0d rf=%b csr=%b wb=%0d h=%b e=%b ir=%0d expected st=%0d req=%b%b%b%b pc_we=%b pc_sel=%0d rf=%b csr=%b wb=%0d h=%b e=%b ir=%0d",
                 $time, c_act.st, c_act.imem_req, c_act.ir_we, c_act.dmem_req, c_act.dmem_we,
                 c_act.pc_we, c_act.pc_sel, c_act.rf_we, c_act.csr_we, c_act.wb_sel,
                 c_act.halted, c_act.error, c_act.instret,
                 c_exp.st, c_exp.imem_req, c_exp.ir_we, c_exp.dmem_req, c_exp.dmem_we,
                 c_exp.pc_we, c_exp.pc_sel, c_exp.rf_we, c_exp.csr_we, c_exp.wb_sel,
                 c_exp.halted, c_exp.error, c_exp.instret);
      end

      n_checks++;
      if (c_act4 !== c_exp4) begin
        n_errors++;
        $display("FAIL trace4 t=%0t got %h expected %h", $time, c_act4, c_exp4);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic put(input obs_t e);
    exp_q.push_back(OBS_W'(e));
    n_push++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t idle(input logic [2:0] s);
    obs_t e;
    e         = '0;
    e.st      = s;
    e.instret = m_instret;
    e.halted  = (s == 3'd5);
    e.error   = (s == 3'd6);
    return e;
  endfunction

  // Expected write-back cycle, straight from the instruction's flags.
  function automatic obs_t wb_exp(input flags_t f, input logic brt);
    obs_t e;
    e        = idle(3'd4);
    e.pc_we  = 1'b1;
    e.rf_we  = f.reg_write && !f.mem_write && !f.branch;
    e.csr_we = f.csr_write;
    if (f.jalr)                        e.pc_sel = 2'd2;
    else if (f.jal || (f.branch && brt)) e.pc_sel = 2'd1;
    else                               e.pc_sel = 2'd0;
    if (f.jal || f.jalr)               e.wb_sel = 2'd2;
    else if (f.mem_read)               e.wb_sel = 2'd1;
    else                               e.wb_sel = 2'd0;
    return e;
  endfunction

  task automatic apply_flags(input flags_t f, input logic brt);
    {jal, jalr, branch, mem_read, mem_write, reg_write, csr_write, illegal} = f;
    br_taken = brt;
  endtask

  task automatic garbage_flags();
    apply_flags(flags_t'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      reset     = 1'b0;
      imem_ack  = 1'b1;
      dmem_ack  = 1'b1;
      halt_req  = 1'b1;
      garbage_flags();
      m_instret = 32'd0;
      put(idle(3'd0));
    end
  endtask

  // FETCH cycles: iw cycles without ack, then one with ack.
  task automatic fetch(input int iw);
    obs_t e;
    for (int i = 0; i <= iw; i++) begin
      tick();
      garbage_flags();
      imem_ack   = (i == iw);
      dmem_ack   = 1'($urandom_range(0, 1));
      halt_req   = 1'b0;
      e          = idle(3'd0);
      e.imem_req = 1'b1;
      e.ir_we    = (i == iw);
      put(e);
    end
  endtask

  // One full instruction. hold < 0: no halt; otherwise halt_req is kept
  // high for hold HALT cycles before being released.
  task automatic run_instr(input flags_t f, input logic brt, input int iw,
                           input int dw, input int hold);
    obs_t e;
    fetch(iw);
    tick();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    apply_flags(f, brt);
    put(idle(3'd1));
    if (f.illegal) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        put(idle(3'd6));
      end
      return;
    end
    tick();
    put(idle(3'd2));
    if (f.mem_read || f.mem_write) begin
      for (int i = 0; i <= dw; i++) begin
        tick();
        dmem_ack   = (i == dw);
        imem_ack   = 1'($urandom_range(0, 1));
        e          = idle(3'd3);
        e.dmem_req = 1'b1;
        e.dmem_we  = f.mem_write;
        put(e);
      end
    end
    tick();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    halt_req = (hold >= 0);
    put(wb_exp(f, brt));
    m_instret = m_instret + 32'd1;
    if (hold >= 0) begin
      for (int i = 0; i <= hold; i++) begin
        tick();
        halt_req = (i < hold);
        imem_ack = 1'($urandom_range(0, 1));
        put(idle(3'd5));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   p0, k, iw, dw, hold;
    obs_t e;

    n_checks  = 0;
    n_errors  = 0;
    n_push    = 0;
    m_instret = 32'd0;
    reset     = 1'b0;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    halt_req  = 1'b0;
    apply_flags(8'd0, 1'b0);

    do_reset(2);

    // ADD with immediate fetch ack: 4 cycles, one retire.
    p0 = n_push;
    run_instr(F_ADD, 1'b0, 0, 0, -1);
    chk("add_cycles", n_push - p0, 4);
    chk("model_instret_add", m_instret, 1);

    // LW with 3 data wait cycles: 8 cycles in total.
    p0 = n_push;
    run_instr(F_LW, 1'b0, 0, 3, -1);
    chk("lw_cycles", n_push - p0, 8);

    run_instr(F_SW,    1'b0, 1, 0, -1);
    run_instr(F_BEQ,   1'b1, 0, 0, -1);
    run_instr(F_BEQ,   1'b0, 0, 0, -1);
    run_instr(F_JALR,  1'b0, 0, 0, -1);
    run_instr(F_JAL,   1'b1, 2, 0, -1);
    run_instr(F_CSR,   1'b0, 0, 0, -1);
    run_instr(F_SW_RW, 1'b0, 0, 1, -1);
    run_instr(F_BR_RW, 1'b1, 0, 0, -1);

    // Halt: held for two HALT cycles, then immediately released.
    run_instr(F_ADD, 1'b0, 0, 0, 2);
    run_instr(F_ADD, 1'b0, 0, 0, 0);
    chk("model_instret_dir", m_instret, 12);

    // Reset during MEM abandons the load.
    fetch(0);
    tick();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    apply_flags(F_LW, 1'b0);
    put(idle(3'd1));
    tick();
    put(idle(3'd2));
    for (int i = 0; i < 2; i++) begin
      tick();
      e          = idle(3'd3);
      e.dmem_req = 1'b1;
      put(e);
    end
    tick();
    reset     = 1'b0;
    dmem_ack  = 1'b1;
    m_instret = 32'd0;
    put(idle(3'd0));
    tick();
    dmem_ack   = 1'b0;
    e          = idle(3'd0);
    e.imem_req = 1'b1;
    put(e);
    #1;
    chk("instret_after_mem_reset", instret, 0);
    chk("dmem_req_after_mem_reset", {31'd0, dmem_req}, 0);
    run_instr(F_ADD, 1'b0, 0, 0, -1);

    // Fetch never acknowledged: 16 FETCH cycles, then ERROR that acks
    // cannot leave.
    do_reset(1);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      imem_ack   = 1'b0;
      e          = idle(3'd0);
      e.imem_req = 1'b1;
      put(e);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      halt_req = 1'($urandom_range(0, 1));
      put(idle(3'd6));
    end
    #1;
    chk("error_sticky", {31'd0, error}, 1);
    do_reset(1);

    // Ack in the last allowed wait cycle, then an illegal opcode.
    run_instr(F_ILL, 1'b0, TIMEOUT - 1, 0, -1);
    do_reset(1);

    // 16 retires wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      run_instr(F_ADD, 1'b0, $urandom_range(0, 1), 0, -1);
    end
    tick();
    imem_ack   = 1'b0;
    e          = idle(3'd0);
    e.imem_req = 1'b1;
    put(e);
    #1;
    chk("instret4_wrap", {28'd0, instret_4}, 0);
    chk("instret32_16", instret, 16);
    do_reset(1);

    // Random instruction mix with random wait states and halts.
    for (int n = 0; n < 60; n++) begin
      k    = $urandom_range(0, 8);
      iw   = ($urandom_range(0, 7) == 0) ? (TIMEOUT - 1) : $urandom_range(0, 2);
      dw   = ($urandom_range(0, 7) == 0) ? (TIMEOUT - 1) : $urandom_range(0, 3);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(KINDS[k], 1'($urandom_range(0, 1)), iw, dw, hold);
    end

    tick();
    tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback, handshaking with instruction and data memory.
- Consumes the decoder's control flags and drives the write enables and mux selects for PC, IR, register file and CSR file.
- Tracks memory-wait timeouts, halt requests and the retired-instruction count.

Parameters:
- TIMEOUT, 16, max cycles waiting for imem_ack/dmem_ack before ERROR; 0 disables timeout.
- CNT_W, 32, width of instret counter.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction valid this cycle
- ir_we  out  1  load instruction register
- jal, jalr, branch, mem_read, mem_write, reg_write, csr_write  in  1 each  decoder flags for current IR
- illegal  in  1  IR is not a supported opcode
- br_taken  in  1  ALU compare result (bit 0)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ack  in  1  data access complete
- pc_we  out  1  update PC
- pc_sel  out  2  0 = pc+4, 1 = pc+imm, 2 = ALU result (jalr)
- rf_we  out  1  register file write
- csr_we  out  1  CSR write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = pc+4
- halt_req  in  1  stop at next instruction boundary
- halted  out  1  in HALT state
- error  out  1  sticky fault flag
- state_o  out  3  current state encoding
- instret  out  CNT_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- Reset (reset==0 at posedge):
  - state=FETCH, instret=0, error=0, timeout counter=0.
  - All outputs are 0 while reset is low.
  - Acks seen during reset are ignored.
  - Reset mid-instruction abandons it; no write enable fires.
- FETCH:
  - imem_req=1 every cycle in state.
  - On imem_ack: ir_we=1 that same cycle (Mealy), next state DECODE.
- DECODE: one cycle. illegal=1 -> ERROR, else -> EXEC.
- EXEC: one cycle. mem_read|mem_write -> MEM, else -> WB.
- MEM:
  - dmem_req=1; dmem_we=mem_write.
  - Held until dmem_ack, then -> WB (loads and stores alike).
- WB: one cycle.
  - pc_we=1.
  - rf_we = reg_write & ~mem_write & ~branch.
  - csr_we = csr_write.
  - instret += 1, wrapping modulo 2^CNT_W.
  - Next: halt_req ? HALT : FETCH.
- pc_sel (valid in WB; 0 elsewhere): jalr -> 2; jal | (branch & br_taken) -> 1; else 0.
- wb_sel: jal|jalr -> 2; mem_read -> 1; else 0.
- HALT: halted=1, no requests. Leaves to FETCH in the cycle after halt_req deasserts.
- ERROR:
  - error=1; all enables and requests 0.
  - Exit only by reset.
- Timeout:
  - Counter clears on entering FETCH or MEM.
  - Increments each cycle in FETCH/MEM without ack.
  - If counter==TIMEOUT-1 and no ack that cycle -> ERROR.
  - Ack in the expiry cycle wins (normal progress).
- Latency: ALU/jump/branch instruction with zero-wait ack = 4 cycles; load/store with zero-wait acks = 5 cycles.
- Decoder flags and br_taken are sampled combinationally and are stable from DECODE through WB.
- halt_req is honoured only in WB.

Test Plan:
- ADD (reg_write=1), imem_ack immediate -> states 0,1,2,4; ir_we in cycle 1; rf_we=1, pc_sel=0, wb_sel=0 in cycle 4; instret=1.
- LW, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0; WB has rf_we=1, wb_sel=1; total 8 cycles.
- SW -> dmem_we=1 during MEM; rf_we=0 in WB. BEQ with br_taken=1 -> pc_sel=1; with br_taken=0 -> pc_sel=0; rf_we=0 both. JALR -> pc_sel=2, wb_sel=2.
- TIMEOUT=16, imem_ack never asserted -> ERROR after 16 FETCH cycles; error stays 1 with acks applied until reset low.
- Ack exactly in the 16th wait cycle -> no ERROR, proceeds to DECODE. illegal=1 in DECODE -> ERROR next cycle.
- halt_req high during WB -> HALT, halted=1, no imem_req; deassert -> FETCH next cycle.
- Reset pulled low during MEM -> next cycle state=FETCH, instret=0, dmem_req=0.
- CNT_W=4 with 16 retires -> instret wraps to 0.
